jk_cmd_sequencer: RTL and testbench

- Upstream driver for the JK flip-flop stage.
- Accepts high-level commands (hold, reset, set, toggle, each with a repeat length) over a valid/ready handshake and buffers them in a small FIFO.
- Replays each command onto registered j/k outputs for the requested number of cycles.
- Optionally checks the flop's returned q against an internal reference model.

---
 rtl/jk_cmd_sequencer.sv | 104 ++++++++++
 tb/tb_jk_cmd_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: buffers {j,k} hold/reset/set/toggle commands in a FIFO and replays each for len+1 cycles.
// Define JKSEQ_CHECK_EN to build the q_fb reference model and sticky mismatch flag.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [LEN_W-1:0]         cmd_len,
    output logic                     j,
    output logic                     k,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    input  logic                     q_fb,
    input  logic                     clr_err,
    output logic                     mismatch
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {IDLE, DRIVE} state_t;
    state_t state, state_nx;
    logic [LEN_W+1:0] mem [DEPTH];
    logic [LEN_W+1:0] head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LEN_W-1:0] remain, remain_nx;
    logic j_nx, k_nx, busy_nx, push, pop;
    assign cmd_ready = fifo_level != (AW+1)'(DEPTH);
    assign push = cmd_valid && cmd_ready;
    // Pop on the last drive cycle too, so consecutive commands have no bubble.
    assign pop = (fifo_level != '0) && (state == IDLE || remain == '0);
    assign head = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_op, cmd_len};
    end
    always_comb begin
        state_nx = state;
        remain_nx = remain;
        j_nx = j;
        k_nx = k;
        busy_nx = busy;
        if (pop) begin
            state_nx = DRIVE;
            {j_nx, k_nx} = head[LEN_W+:2];
            remain_nx = head[LEN_W-1:0];
            busy_nx = 1'b1;
        end else if (state == DRIVE) begin
            if (remain != '0) begin
                remain_nx = remain - LEN_W'(1);
            end else begin
                state_nx = IDLE;
                j_nx = 1'b0;
                k_nx = 1'b0;
                busy_nx = 1'b0;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            remain <= '0;
            j <= 1'b0;
            k <= 1'b0;
            busy <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_level <= '0;
        end else begin
            state <= state_nx;
            remain <= remain_nx;
            j <= j_nx;
            k <= k_nx;
            busy <= busy_nx;
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
`ifdef JKSEQ_CHECK_EN
    logic exp_q, armed, chk_pend, mis_r;
    // The flop powers up unknown, so checking starts only after a set or reset edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= 1'b0;
            armed <= 1'b0;
            chk_pend <= 1'b0;
            mis_r <= 1'b0;
        end else begin
            if (busy) begin
                exp_q <= (j && k) ? !exp_q : j ? 1'b1 : k ? 1'b0 : exp_q;
                armed <= armed || (j ^ k);
            end
            chk_pend <= busy && (armed || (j ^ k));
            mis_r <= (mis_r && !clr_err) || (chk_pend && q_fb != exp_q);
        end
    end
    assign mismatch = mis_r;
`else
    logic unused_chk;
    assign unused_chk = q_fb ^ clr_err;
    assign mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb_jk_cmd_sequencer: directed tests of jk_cmd_sequencer against a behavioural JK flop.
// Mismatch expectations follow JKSEQ_CHECK_EN.
module tb_jk_cmd_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_len = 4'd0;
    logic j, k, busy, mismatch;
    logic [2:0] fifo_level;
    logic clr_err = 1'b0;
    logic q_flop = 1'b0;
    logic q_force = 1'b0;
    logic q_fb;
    int checks = 0;
    int errors = 0;
`ifdef JKSEQ_CHECK_EN
    localparam logic EXP_MIS = 1'b1;
`else
    localparam logic EXP_MIS = 1'b0;
`endif
    assign q_fb = q_force ? 1'b0 : q_flop;
    always #5 clk = ~clk;
    always @(posedge clk) q_flop <= (j && k) ? !q_flop : j ? 1'b1 : k ? 1'b0 : q_flop;
    jk_cmd_sequencer #(.DEPTH(4), .LEN_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .j(j), .k(k), .busy(busy),
        .fifo_level(fifo_level), .q_fb(q_fb), .clr_err(clr_err), .mismatch(mismatch)
    );
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        rst_n = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = 2'b10;
        cmd_len = 4'd0;
        repeat (3) step();
        checks++;
        if ({cmd_ready, j, k, busy, fifo_level, mismatch} !== 8'b1_0_0_0_000_0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b j=%b k=%b busy=%b lvl=%0d mis=%b want 1 0 0 0 0 0", cmd_ready, j, k, busy, fifo_level, mismatch);
        end
        rst_n = 1'b1;
        step();
        cmd_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd1 || j !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_accept got lvl=%0d j=%b want 1 0", fifo_level, j);
        end
        step();
        checks++;
        if ({j, k, busy} !== 3'b101) begin
            errors++;
            $display("FAIL reset_first_drive got jkb=%b want 101", {j, k, busy});
        end
        step();
        checks++;
        if ({j, k, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_first_end got jkb=%b want 000", {j, k, busy});
        end
    endtask
    task automatic test_single;
        cmd_valid = 1'b1;
        cmd_op = 2'b10;
        cmd_len = 4'd2;
        step();
        cmd_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_accept got lvl=%0d busy=%b want 1 0", fifo_level, busy);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({j, k, busy} !== 3'b101) begin
                errors++;
                $display("FAIL single_drive[%0d] got jkb=%b want 101", i, {j, k, busy});
            end
        end
        step();
        checks++;
        if ({j, k, busy} !== 3'b000) begin
            errors++;
            $display("FAIL single_end got jkb=%b want 000", {j, k, busy});
        end
        checks++;
        if (q_flop !== 1'b1 || mismatch !== 1'b0) begin
            errors++;
            $display("FAIL single_q got q=%b mis=%b want 1 0", q_flop, mismatch);
        end
    endtask
    task automatic test_back_to_back;
        logic [1:0] exp_jk [9] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        logic exp_q [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0] ops [4] = '{2'b01, 2'b11, 2'b11, 2'b10};
        logic [3:0] lens [4] = '{4'd0, 4'd1, 4'd0, 4'd0};
        fork
            begin
                int n = 0;
                cmd_valid = 1'b1;
                cmd_op = 2'b10;
                cmd_len = 4'd15;
                step();
                for (int i = 0; i < 4; i++) begin
                    cmd_op = ops[i];
                    cmd_len = lens[i];
                    step();
                end
                checks++;
                if (fifo_level !== 3'd4 || cmd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_full got lvl=%0d rdy=%b want 4 0", fifo_level, cmd_ready);
                end
                cmd_op = 2'b00;
                cmd_len = 4'd3;
                while (!cmd_ready && n < 40) begin
                    step();
                    n++;
                end
                checks++;
                if (n == 40 || fifo_level !== 3'd3) begin
                    errors++;
                    $display("FAIL fill_refuse_on_pop got lvl=%0d waited=%0d want 3 <40", fifo_level, n);
                end
                step();
                cmd_valid = 1'b0;
            end
            begin
                int n = 0;
                while (!(j == 1'b0 && k == 1'b1) && n < 60) begin
                    step();
                    n++;
                end
                checks++;
                if (n == 60) begin
                    errors++;
                    $display("FAIL b2b_start got timeout want jk=01");
                end
                for (int i = 0; i < 9; i++) begin
                    checks++;
                    if ({j, k, busy} !== {exp_jk[i], 1'b1}) begin
                        errors++;
                        $display("FAIL b2b_jk[%0d] got jkb=%b want %b1", i, {j, k, busy}, exp_jk[i]);
                    end
                    step();
                    checks++;
                    if (q_flop !== exp_q[i]) begin
                        errors++;
                        $display("FAIL b2b_q[%0d] got %b want %b", i, q_flop, exp_q[i]);
                    end
                end
                checks++;
                if ({j, k, busy, mismatch} !== 4'b0000 || fifo_level !== 3'd0) begin
                    errors++;
                    $display("FAIL b2b_end got jkbm=%b lvl=%0d want 0000 0", {j, k, busy, mismatch}, fifo_level);
                end
            end
        join
    endtask
    task automatic test_checker;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 2'b11;
        cmd_len = 4'd1;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({j, k, busy} !== 3'b111) begin
                errors++;
                $display("FAIL chk_toggle[%0d] got jkb=%b want 111", i, {j, k, busy});
            end
        end
        step();
        step();
        checks++;
        if (mismatch !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL chk_unarmed got mis=%b busy=%b want 0 0", mismatch, busy);
        end
        cmd_valid = 1'b1;
        cmd_op = 2'b10;
        cmd_len = 4'd0;
        step();
        cmd_valid = 1'b0;
        step();
        checks++;
        if ({j, k, busy} !== 3'b101) begin
            errors++;
            $display("FAIL chk_set_drive got jkb=%b want 101", {j, k, busy});
        end
        step();
        checks++;
        if ({j, k, busy, mismatch} !== 4'b0000) begin
            errors++;
            $display("FAIL chk_set_end got jkbm=%b want 0000", {j, k, busy, mismatch});
        end
        q_force = 1'b1;
        step();
        q_force = 1'b0;
        checks++;
        if (mismatch !== EXP_MIS) begin
            errors++;
            $display("FAIL chk_detect got %b want %b", mismatch, EXP_MIS);
        end
        step();
        step();
        checks++;
        if (mismatch !== EXP_MIS) begin
            errors++;
            $display("FAIL chk_sticky got %b want %b", mismatch, EXP_MIS);
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++;
        if (mismatch !== 1'b0) begin
            errors++;
            $display("FAIL chk_clear got %b want 0", mismatch);
        end
        step();
        checks++;
        if (mismatch !== 1'b0) begin
            errors++;
            $display("FAIL chk_stay_clear got %b want 0", mismatch);
        end
    endtask
    task automatic test_reset_mid;
        cmd_valid = 1'b1;
        cmd_op = 2'b11;
        cmd_len = 4'd7;
        step();
        cmd_op = 2'b01;
        cmd_len = 4'd0;
        step();
        cmd_op = 2'b10;
        step();
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || fifo_level !== 3'd2) begin
            errors++;
            $display("FAIL mid_pre got busy=%b lvl=%0d want 1 2", busy, fifo_level);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({j, k, busy} !== 3'b000 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL mid_async got jkb=%b lvl=%0d want 000 0", {j, k, busy}, fifo_level);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({j, k, busy} !== 3'b000 || fifo_level !== 3'd0) begin
                errors++;
                $display("FAIL mid_quiet[%0d] got jkb=%b lvl=%0d want 000 0", i, {j, k, busy}, fifo_level);
            end
        end
    endtask
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_checker();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
